// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and types for the synchronous byte FIFO.
//   FIFO_WIDTH  : default data word width in bits
//   FIFO_DEPTH  : default number of storage entries (power of two)
//   FIFO_ADDR_W : default pointer width, log2(FIFO_DEPTH)
//   word_t      : one data word
//   ptr_t       : one read/write pointer
//   cnt_t       : occupancy count, 0..FIFO_DEPTH (one bit wider than ptr_t)
// No optional-feature macros are used in this file.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_WIDTH  = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_ADDR_W = 4;

  typedef logic [FIFO_WIDTH-1:0] word_t;
  typedef logic [FIFO_ADDR_W-1:0] ptr_t;
  typedef logic [FIFO_ADDR_W:0]   cnt_t;

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
// Wrapping ADDR_W-bit pointer. Advances by one on every clock edge where inc
// is high; wraps from 2**ADDR_W-1 back to 0 through plain binary overflow.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous reset, active low (clears the pointer to 0)
//   inc : advance the pointer this cycle
//   ptr : current pointer value
// No optional-feature macros are used in this file.
// -----------------------------------------------------------------------------
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] ptr_q;

  // The FIFO depth equals 2**ADDR_W, so the natural overflow of the
  // addition is exactly the wrap from DEPTH-1 to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (inc) begin
      ptr_q <= ptr_q + PTR_ONE;
    end
  end

  assign ptr = ptr_q;

endmodule : fifo_ptr

// File: rtl/fifo_sync.sv
// -----------------------------------------------------------------------------
// fifo_sync
// Single-clock FIFO, DEPTH entries of WIDTH bits, with registered read data
// and an occupancy count. Full and empty are decoded from the count.
//
// Handshake: a write is accepted on a rising edge where wen=1 and full=0;
// wdata is stored on that edge. A read is accepted on a rising edge where
// ren=1 and empty=0; the head word appears on rdata right after that edge
// (one-cycle latency) and rdata holds its value until the next accepted read.
// Requests made while full (write) or empty (read) are dropped with no side
// effects; there is no read-through of a same-cycle write.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst   : asynchronous reset, active low
//   wen   : write request
//   wdata : write data, sampled when a write is accepted
//   ren   : read request
//   rdata : registered read data
//   full  : count == DEPTH
//   empty : count == 0
//   count : current occupancy, 0..DEPTH
//
// Optional feature: define FIFO_ASSERT_EN to add past-cycle tracking
// registers, invariant and pointer-stability assertions, and cover points.
// All of it is gated off while rst is low. With the macro undefined the
// block contains only the datapath below.
// -----------------------------------------------------------------------------
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,   // must equal 2**ADDR_W
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              ren,
  output logic [WIDTH-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] CNT_FULL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count_q;
  logic [WIDTH-1:0]  rdata_q;
  logic              wr_ok;
  logic              rd_ok;

  // Flags come straight from the count so they can never disagree with it.
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // Accept decisions use the state at the start of the cycle: a write into
  // a full FIFO is refused even if a read frees a slot on the same edge.
  assign wr_ok = wen & ~full;
  assign rd_ok = ren & ~empty;

  fifo_ptr #(
    .ADDR_W (ADDR_W)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_ok),
    .ptr (wptr)
  );

  fifo_ptr #(
    .ADDR_W (ADDR_W)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_ok),
    .ptr (rptr)
  );

  // Storage has no reset; entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (rd_ok) begin
      rdata_q <= mem[rptr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign count = count_q;

`ifdef FIFO_ASSERT_EN
  // Previous-cycle copies of the request inputs, flags and pointers. At a
  // given edge these hold the values that decided the previous update.
  logic              past_valid;
  logic              wen_q;
  logic              ren_q;
  logic              full_q;
  logic              empty_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W-1:0] rptr_q;
  logic              seen_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      past_valid <= 1'b0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      wptr_q     <= '0;
      rptr_q     <= '0;
      seen_full  <= 1'b0;
    end else begin
      past_valid <= 1'b1;
      wen_q      <= wen;
      ren_q      <= ren;
      full_q     <= full;
      empty_q    <= empty;
      wptr_q     <= wptr;
      rptr_q     <= rptr;
      if (full) begin
        seen_full <= 1'b1;
      end
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    count_q <= CNT_FULL);

  // Pointer difference modulo DEPTH is just ADDR_W-bit subtraction.
  a_ptr_count: assert property (@(posedge clk) disable iff (!rst)
    (ADDR_W'(wptr - rptr)) == count_q[ADDR_W-1:0]);

  a_flags_excl: assert property (@(posedge clk) disable iff (!rst)
    !(full && empty));

  a_rptr_hold: assert property (@(posedge clk) disable iff (!rst)
    (past_valid && (!ren_q || empty_q)) |-> (rptr == rptr_q));

  a_wptr_hold: assert property (@(posedge clk) disable iff (!rst)
    (past_valid && (!wen_q || full_q)) |-> (wptr == wptr_q));

  c_full: cover property (@(posedge clk) disable iff (!rst)
    full);

  c_empty_after_full: cover property (@(posedge clk) disable iff (!rst)
    seen_full && empty);

  c_wptr_wrap: cover property (@(posedge clk) disable iff (!rst)
    past_valid && (wptr_q == {ADDR_W{1'b1}}) && (wptr == '0));

  c_rptr_wrap: cover property (@(posedge clk) disable iff (!rst)
    past_valid && (rptr_q == {ADDR_W{1'b1}}) && (rptr == '0));
`endif

endmodule : fifo_sync

// File: tb/tb_fifo_sync.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync
// Self-checking bench for fifo_sync (default 16 x 8 configuration).
// A directed vector table covers reset, basic ordering and underflow; hand
// sequences backed by an expected-data queue cover fill/overflow, full with
// simultaneous read, pointer wrap under continuous traffic and an
// asynchronous reset between clock edges.
// -----------------------------------------------------------------------------
module tb_fifo_sync;
  import fifo_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic       wen;
  logic       ren;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       full;
  logic       empty;
  logic [4:0] count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_sync dut (
    .clk   (clk),
    .rst   (rst),
    .wen   (wen),
    .wdata (wdata),
    .ren   (ren),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // ---------------- scoreboard ----------------
  int         checks;
  int         failures;
  logic [7:0] exp_q[$];
  logic [7:0] exp_rdata;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [4:0] e_cnt,
                               input logic e_emp, input logic e_ful,
                               input logic [7:0] e_rd);
    check({tag, ".count"}, 32'(count), 32'(e_cnt));
    check({tag, ".empty"}, 32'(empty), 32'(e_emp));
    check({tag, ".full"},  32'(full),  32'(e_ful));
    check({tag, ".rdata"}, 32'(rdata), 32'(e_rd));
  endtask

  // ---------------- driver with queue model ----------------
  // One clock cycle of requests; the expected queue decides acceptance from
  // its own occupancy, then outputs are compared just after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d,
                      input string tag);
    logic wr_acc;
    logic rd_acc;
    @(negedge clk);
    wen   = w;
    ren   = r;
    wdata = d;
    wr_acc = w && (exp_q.size() < 16);
    rd_acc = r && (exp_q.size() > 0);
    if (rd_acc) exp_rdata = exp_q.pop_front();
    if (wr_acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    check_outputs(tag, 5'(exp_q.size()), exp_q.size() == 0,
                  exp_q.size() == 16, exp_rdata);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic       wen;
    logic       ren;
    logic [7:0] wdata;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic [7:0] rd;
    string      name;
  } vec_t;

  vec_t vecs[11];

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    wen       = 1'b0;
    ren       = 1'b0;
    wdata     = 8'h00;
    exp_rdata = 8'h00;

    //                rst  wen  ren  wdata  cnt   emp  ful  rdata
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 8'h01, 5'd0, 1'b1, 1'b0, 8'h00, "rst_hold"};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 8'h00, "rst_release"};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 8'h00, "wr_11"};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h22, 5'd2, 1'b0, 1'b0, 8'h00, "wr_22"};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h33, 5'd3, 1'b0, 1'b0, 8'h00, "wr_33"};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h00, 5'd2, 1'b0, 1'b0, 8'h11, "rd_11"};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h00, 5'd1, 1'b0, 1'b0, 8'h22, "rd_22"};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 8'h33, "rd_33"};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 8'h33, "underflow"};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0, 8'h33, "wr_rd_empty"};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 8'hA5, "rd_a5"};

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst   = vecs[i].rst;
      wen   = vecs[i].wen;
      ren   = vecs[i].ren;
      wdata = vecs[i].wdata;
      @(posedge clk);
      #1;
      check_outputs(vecs[i].name, vecs[i].cnt, vecs[i].emp, vecs[i].ful,
                    vecs[i].rd);
    end

    // Table leaves the FIFO empty with 0xA5 on rdata.
    exp_q.delete();
    exp_rdata = 8'hA5;

    // ---------------- fill / overflow ----------------
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i), $sformatf("fill%0d", i));
    end
    step(1'b1, 1'b0, 8'hFF, "overflow_wr");
    // Full with both requests: read proceeds, write is refused.
    step(1'b1, 1'b1, 8'hEE, "full_wr_rd");
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 8'h00, $sformatf("drain%0d", i));
    end
    step(1'b0, 1'b1, 8'h00, "drain_underflow");

    // ---------------- simultaneous traffic across the wrap ----------------
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'(8'h40 + i), $sformatf("preload%0d", i));
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(8'h80 + i), $sformatf("stream%0d", i));
    end

    // ---------------- asynchronous reset mid-operation ----------------
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h00, $sformatf("pre_rst_rd%0d", i));
    end
    check("pre_rst.count", 32'(count), 32'd5);
    @(negedge clk);
    wen = 1'b0;
    ren = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_outputs("async_rst", 5'd0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_rdata = 8'h00;
    step(1'b1, 1'b0, 8'h5A, "post_rst_wr");
    step(1'b0, 1'b1, 8'h00, "post_rst_rd");

    @(negedge clk);
    wen = 1'b0;
    ren = 1'b0;

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fifo_sync
